// File: rtl/calc_pkg.sv
// Shared opcode definitions for the calculator logic unit.
// Imported by the combinational function block and the pipeline top.
package calc_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/calc_logic_op.sv
// Combinational two-operand bitwise function block.
// Opcodes OP_NOT and OP_PASS ignore operand b.
module calc_logic_op
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XNOR: result = ~(a ^ b);
            OP_NOT:  result = ~a;
            OP_PASS: result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/calc_logic_unit.sv
// Two-stage valid/ready bitwise logic unit with accumulator operand,
// zero/parity flags and a wrapping output-handshake counter.
module calc_logic_unit
    import calc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [OP_W-1:0]    in_op,
    input  logic               in_acc_sel,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_zero,
    output logic               out_parity,
    output logic [COUNT_W-1:0] op_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic             s1_acc_sel;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_res;

    logic s2_load;
    logic in_fire;
    logic out_fire;

    // S1 drains into S2 whenever S2 is empty or emptying this edge
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign op_b = s1_acc_sel ? acc : s1_b;

    calc_logic_op #(
        .WIDTH (WIDTH)
    ) u_op (
        .a      (s1_a),
        .b      (op_b),
        .op     (s1_op),
        .result (op_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= OP_AND;
            s1_acc_sel <= 1'b0;
        end else if (in_fire) begin
            s1_valid   <= 1'b1;
            s1_a       <= in_a;
            s1_b       <= in_b;
            s1_op      <= op_e'(in_op);
            s1_acc_sel <= in_acc_sel;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_parity <= 1'b0;
        end else if (s2_load) begin
            out_valid  <= 1'b1;
            out_result <= op_res;
            out_zero   <= (op_res == '0);
            out_parity <= ^op_res;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Clear takes priority over the result write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (s2_load) begin
            acc <= op_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_fire) begin
            op_count <= op_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_calc_logic_unit.sv
// Self-checking bench for calc_logic_unit: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_calc_logic_unit;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [2:0]    in_op;
    logic          in_acc_sel;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_zero;
    logic          out_parity;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    calc_logic_unit #(
        .WIDTH   (W),
        .COUNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_acc_sel (in_acc_sel),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .op_count   (op_count)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       sel;
    } txn_t;

    // Reference: accepted-but-unevaluated work, produced results, acc, count
    txn_t       pend[$];
    logic [7:0] outq[$];
    logic [7:0] m_acc;
    int         m_cnt;

    logic [7:0] got[$];
    logic       got_z[$];
    logic       got_p[$];

    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_fn(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    task automatic model_clear();
        pend.delete();
        outq.delete();
        got.delete();
        got_z.delete();
        got_p.delete();
        m_acc = 8'h00;
        m_cnt = 0;
    endtask

    // One clock: drive at negedge, check, then advance the model
    task automatic step(input logic v, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] op,
                        input logic sel, input logic clr,
                        input logic ordy);
        logic       load;
        logic       accept;
        logic [7:0] r;
        logic [7:0] bb;
        txn_t       t;
        txn_t       nt;
        @(negedge clk);
        in_valid   = v;
        in_a       = a;
        in_b       = b;
        in_op      = op;
        in_acc_sel = sel;
        acc_clr    = clr;
        out_ready  = ordy;
        #1;
        load = (pend.size() > 0) && (outq.size() == 0 || ordy);
        chk("in_ready", 32'(in_ready),
            32'((pend.size() == 0) || load));
        chk("out_valid", 32'(out_valid), 32'(outq.size() != 0));
        if (outq.size() != 0) begin
            chk("out_result", 32'(out_result), 32'(outq[0]));
            chk("out_zero", 32'(out_zero), 32'(outq[0] == 8'h00));
            chk("out_parity", 32'(out_parity), 32'(^outq[0]));
        end
        chk("op_count", 32'(op_count), 32'(m_cnt % 16));
        if (out_valid && out_ready) begin
            got.push_back(out_result);
            got_z.push_back(out_zero);
            got_p.push_back(out_parity);
        end
        accept = v && ((pend.size() == 0) || load);
        r = 8'h00;
        if (outq.size() != 0 && ordy) begin
            void'(outq.pop_front());
            m_cnt++;
        end
        if (load) begin
            t  = pend.pop_front();
            bb = t.sel ? m_acc : t.b;
            r  = ref_fn(t.a, bb, t.op);
            outq.push_back(r);
        end
        if (clr) m_acc = 8'h00;
        else if (load) m_acc = r;
        if (accept) begin
            nt.a   = a;
            nt.b   = b;
            nt.op  = op;
            nt.sel = sel;
            pend.push_back(nt);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_op_count", 32'(op_count), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] sweep_exp [8];
    logic [7:0] ra;
    logic [7:0] rb;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        model_clear();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_op      = '0;
        in_acc_sel = 1'b0;
        acc_clr    = 1'b0;
        out_ready  = 1'b0;
        #2;
        chk("init_in_ready", 32'(in_ready), 32'd1);
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_result", 32'(out_result), 32'd0);
        chk("init_zero", 32'(out_zero), 32'd0);
        chk("init_parity", 32'(out_parity), 32'd0);
        chk("init_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Function sweep
        sweep_exp = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h3A, 8'hC5};
        for (int op = 0; op < 8; op++)
            step(1'b1, 8'hC5, 8'h3A, 3'(op), 1'b0, 1'b0, 1'b1);
        idle(3);
        chk("sweep_n", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            chk("sweep_res", 32'(got[i]), 32'(sweep_exp[i]));
            chk("sweep_zero", 32'(got_z[i]), 32'(sweep_exp[i] == 8'h00));
            chk("sweep_par", 32'(got_p[i]), 32'd0);
        end
        chk("sweep_count", 32'(op_count), 32'd8);

        // Backpressure: third offer refused until out_ready returns
        do_reset();
        step(1'b1, 8'h11, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        step(1'b1, 8'h33, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1);
        idle(4);
        chk("bp_n", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("bp_r0", 32'(got[0]), 32'h11);
            chk("bp_r1", 32'(got[1]), 32'h22);
            chk("bp_r2", 32'(got[2]), 32'h33);
        end
        chk("bp_count", 32'(op_count), 32'd3);

        // Accumulator chain with XOR
        do_reset();
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h0F, 8'hAA, 3'd2, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'hF0, 8'hAA, 3'd2, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 8'hAA, 3'd2, 1'b1, 1'b0, 1'b1);
        idle(3);
        chk("acc_n", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("acc_r0", 32'(got[0]), 32'h0F);
            chk("acc_r1", 32'(got[1]), 32'hFF);
            chk("acc_r2", 32'(got[2]), 32'h00);
            chk("acc_z2", 32'(got_z[2]), 32'd1);
        end

        // Clear coinciding with an S2 load
        do_reset();
        step(1'b1, 8'h0F, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
        idle(2);
        step(1'b1, 8'h30, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h01, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1);
        idle(3);
        chk("clr_n", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("clr_r1", 32'(got[1]), 32'h3F);
            chk("clr_r2", 32'(got[2]), 32'h01);
        end

        // Reset with two transactions in flight
        idle(1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hAB, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hCD, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        do_reset();
        step(1'b1, 8'h5A, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
        idle(3);
        chk("post_rst_n", 32'(got.size()), 32'd1);
        if (got.size() == 1)
            chk("post_rst_acc0", 32'(got[0]), 32'h5A);

        // Counter wrap with stalled cycles interleaved
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'(i), 8'h00, 3'd7, 1'b0, 1'b0, 1'b1);
            step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        end
        idle(3);
        chk("wrap_n", 32'(got.size()), 32'd17);
        chk("wrap_count", 32'(op_count), 32'd1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            step(1'($urandom_range(0, 3) != 0), ra, rb,
                 3'($urandom_range(0, 7)), 1'($urandom),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 3) != 0));
        end
        idle(4);
        chk("rand_drained", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
